// File: rtl/montgomery_reduce_iter_if.sv
// Handshake and data bundle for the word-serial Montgomery reduction stage.
// The producer side drives the product/modulus; the reducer returns the result.
interface montgomery_reduce_iter_if #(
  parameter int unsigned DATA_LENGTH  = 64,
  parameter int unsigned BLOCK_LENGTH = 16
);
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [2*DATA_LENGTH-1:0]  product_i;
  logic [DATA_LENGTH-1:0]    modulus_i;
  logic [BLOCK_LENGTH-1:0]   n_prime_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [DATA_LENGTH-1:0]    result_o;

  modport master (
    output in_valid_i, product_i, modulus_i, n_prime_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o
  );

  modport slave (
    input  in_valid_i, product_i, modulus_i, n_prime_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o
  );
endinterface

// File: rtl/montgomery_reduce_iter.sv
// Word-serial Montgomery reduction: returns T * 2^-DATA_LENGTH mod N,
// retiring one BLOCK_LENGTH word of the accumulator per REDUCE cycle.
module montgomery_reduce_iter #(
  parameter int unsigned DATA_LENGTH  = 64,
  parameter int unsigned BLOCK_LENGTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  montgomery_reduce_iter_if.slave  bus
);
  localparam int unsigned NUM_BLOCKS = DATA_LENGTH / BLOCK_LENGTH;
  localparam int unsigned ACC_W      = 2 * DATA_LENGTH + 1;
  localparam int unsigned CNT_W      = $clog2(NUM_BLOCKS + 1);
  localparam int unsigned UN_W       = BLOCK_LENGTH + DATA_LENGTH;

  typedef enum logic [1:0] {IDLE, REDUCE, FINAL, DONE} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [DATA_LENGTH-1:0]   mod_q, mod_d;
  logic [BLOCK_LENGTH-1:0]  np_q, np_d;
  logic [DATA_LENGTH-1:0]   result_q, result_d;
  logic                     out_valid_q, out_valid_d;

  logic [BLOCK_LENGTH-1:0]  u;
  logic [UN_W-1:0]          un;
  logic [ACC_W-1:0]         sum;
  logic                     acc_ge_n;
  logic [DATA_LENGTH-1:0]   acc_minus_n;

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o    = result_q;

  // Reduction datapath: fold u*N into the accumulator so its low word clears.
  always_comb begin
    u   = acc_q[BLOCK_LENGTH-1:0] * np_q;
    un  = {{DATA_LENGTH{1'b0}}, u} * {{BLOCK_LENGTH{1'b0}}, mod_q};
    sum = acc_q + {{(ACC_W - UN_W){1'b0}}, un};
    acc_ge_n = (acc_q >= {{(DATA_LENGTH + 1){1'b0}}, mod_q});
    // ACC < 2N, so when ACC >= N the difference fits in DATA_LENGTH bits and
    // only the low word of the subtraction is needed.
    acc_minus_n = acc_q[DATA_LENGTH-1:0] - mod_q;
  end

  // Next-state and register-update logic for the IDLE/REDUCE/FINAL/DONE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mod_d       = mod_q;
    np_d        = np_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          acc_d   = {1'b0, bus.product_i};
          mod_d   = bus.modulus_i;
          np_d    = bus.n_prime_i;
          cnt_d   = '0;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        acc_d = sum >> BLOCK_LENGTH;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_BLOCKS - 1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        result_d    = acc_ge_n ? acc_minus_n : acc_q[DATA_LENGTH-1:0];
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over any handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mod_q       <= '0;
      np_q        <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mod_q       <= mod_d;
      np_q        <= np_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
